// File: rtl/serial_sub_ctrl_pkg.sv
// serial_sub_ctrl_pkg: FSM state encoding and index-width helper for the bit-serial subtractor.
package serial_sub_ctrl_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/serial_sub_ctrl_full_subtractor.sv
// full_subtractor: one-bit a - b - c cell producing a difference bit and a borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic brw
);
    assign diff = a ^ b ^ c;
    assign brw  = (~a & b) | (~(a ^ b) & c);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b - bin over WIDTH cycles with start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);
    localparam int IW = idx_w(WIDTH);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [IW-1:0]    r_idx;
    logic             r_brw;
    logic             r_bout;
    logic             w_d;
    logic             w_brw;
    logic             w_last;

    full_subtractor u_fs (
        .a   (r_a[0]),
        .b   (r_b[0]),
        .c   (r_brw),
        .diff(w_d),
        .brw (w_brw)
    );

    assign w_last = r_idx == IW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        r_state <= rst ? ST_IDLE : w_next;
    end

    always_comb begin
        w_next = (r_state == ST_IDLE) ? (start ? ST_RUN : ST_IDLE) :
                 (r_state == ST_RUN)  ? (w_last ? ST_DONE : ST_RUN) : ST_IDLE;
    end

    always_comb begin
        busy = r_state == ST_RUN;
        done = r_state == ST_DONE;
    end

    // Result bits enter the minuend register from the MSB side as its operand bits leave at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_brw  <= 1'b0;
            r_idx  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_a   <= a;
            r_b   <= b;
            r_brw <= bin;
            r_idx <= '0;
        end else if (r_state == ST_RUN) begin
            r_a   <= {w_d, r_a[WIDTH-1:1]};
            r_b   <= r_b >> 1;
            r_brw <= w_brw;
            r_idx <= r_idx + 1'b1;
            if (w_last) begin
                r_diff <= {w_d, r_a[WIDTH-1:1]};
                r_bout <= w_brw;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;
    // Signed overflow: borrow into the MSB differs from borrow out of it.
    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (r_state == ST_RUN && w_last)
            r_ovf <= r_brw ^ w_brw;
    end
    assign ovf = r_ovf;
`endif

    assign diff = r_diff;
    assign bout = r_bout;
endmodule
